// File: rtl/id_pool_1w2r.sv
// Free-ID pool: circular free-list preloaded with 0..depth-1, two allocate lanes
// (pop) and one return lane (push). Returned IDs become visible one cycle later.
module id_pool_1w2r #(
    parameter int depth  = 8,
    parameter int width  = 32,
    parameter int ptr_sz = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   c_srdy,
    output logic                   c_drdy,
    input  logic [width-1:0]       c_data,
    output logic [1:0]             p_srdy,
    input  logic [1:0]             p_drdy,
    output logic [1:0][width-1:0]  p_data,
    output logic [ptr_sz:0]        usage
);
    localparam logic [ptr_sz:0] full_cnt = (ptr_sz+1)'(depth);
    localparam logic [ptr_sz:0] cnt_one  = (ptr_sz+1)'(1);
    localparam logic [ptr_sz:0] cnt_two  = (ptr_sz+1)'(2);

    logic [width-1:0]  mem [depth];
    logic [ptr_sz-1:0] rd_addr;
    logic [ptr_sz-1:0] wr_addr;
    logic [ptr_sz-1:0] rd_addr_p1;
    logic [ptr_sz:0]   count;
    logic [ptr_sz:0]   count_next;
    logic              empty;
    logic              full;
    logic              push;
    logic [1:0]        pop;
    logic [1:0]        npop;

    // Modulo-depth pointer advance; inc is at most 2, so one conditional subtract suffices.
    function automatic logic [ptr_sz-1:0] ptr_add(input logic [ptr_sz-1:0] ptr,
                                                  input logic [1:0] inc);
        logic [ptr_sz:0] sum;
        sum = {1'b0, ptr} + (ptr_sz+1)'(inc);
        if (sum >= full_cnt)
            sum = sum - full_cnt;
        return sum[ptr_sz-1:0];
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == full_cnt);
    assign rd_addr_p1 = ptr_add(rd_addr, 2'd1);

    // Lane 1 takes the head when lane 0 does not accept, so it can drain the last ID.
    assign p_srdy = {(count >= cnt_two) | ((count == cnt_one) & ~p_drdy[0]), ~empty};

    assign p_data[0] = mem[rd_addr];
    assign p_data[1] = p_drdy[0] ? mem[rd_addr_p1] : mem[rd_addr];

    assign pop  = p_srdy & p_drdy;
    assign npop = {1'b0, pop[0]} + {1'b0, pop[1]};

    // No bypass: a full pool refuses returns even while an allocate fires.
    assign c_drdy = ~full;
    assign push   = c_srdy & c_drdy;

    assign count_next = count + (ptr_sz+1)'(push) - (ptr_sz+1)'(npop);
    assign usage      = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            wr_addr <= '0;
            count   <= full_cnt;
            for (int i = 0; i < depth; i++)
                mem[i] <= width'(i);
        end else begin
            rd_addr <= ptr_add(rd_addr, npop);
            count   <= count_next;
            if (push) begin
                mem[wr_addr] <= c_data;
                wr_addr      <= ptr_add(wr_addr, 2'd1);
            end
        end
    end
endmodule

// File: tb/tb_id_pool_1w2r.sv
// Bench for id_pool_1w2r: vector table plus hand sequences on depth-8 and depth-6
// pools, and a randomized run against a free-list queue model.
module tb_id_pool_1w2r;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             c_srdy = 1'b0;
    logic [31:0]      c_data = '0;
    logic [1:0]       p_drdy = 2'b00;
    logic             c_drdy8, c_drdy6;
    logic [1:0]       p_srdy8, p_srdy6;
    logic [1:0][31:0] p_data8, p_data6;
    logic [3:0]       usage8, usage6;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_pool_1w2r #(.depth(8), .width(32)) dut8 (
        .clk(clk), .rst_n(rst_n), .c_srdy(c_srdy), .c_drdy(c_drdy8), .c_data(c_data),
        .p_srdy(p_srdy8), .p_drdy(p_drdy), .p_data(p_data8), .usage(usage8));

    id_pool_1w2r #(.depth(6), .width(32)) dut6 (
        .clk(clk), .rst_n(rst_n), .c_srdy(c_srdy), .c_drdy(c_drdy6), .c_data(c_data),
        .p_srdy(p_srdy6), .p_drdy(p_drdy), .p_data(p_data6), .usage(usage6));

    typedef struct {
        bit          sel6;
        logic [1:0]  srdy;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  mask;
        logic        cdrdy;
        logic [3:0]  usage;
    } exp_t;

    typedef struct {
        bit          rst;
        logic        c_srdy;
        logic [31:0] c_data;
        logic [1:0]  p_drdy;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        c_srdy = 1'b0;
        p_drdy = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Compare combinational outputs mid-cycle against the oldest scoreboard entry.
    task automatic check_sb();
        exp_t e;
        logic [1:0] srdy;
        logic [1:0][31:0] pd;
        logic cd;
        logic [3:0] us;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e    = sb.pop_front();
        srdy = e.sel6 ? p_srdy6 : p_srdy8;
        pd   = e.sel6 ? p_data6 : p_data8;
        cd   = e.sel6 ? c_drdy6 : c_drdy8;
        us   = e.sel6 ? usage6  : usage8;
        chk("p_srdy", {30'd0, srdy}, {30'd0, e.srdy});
        chk("c_drdy", {31'd0, cd}, {31'd0, e.cdrdy});
        chk("usage",  {28'd0, us}, {28'd0, e.usage});
        if (e.mask[0]) chk("p_data0", pd[0], e.d0);
        if (e.mask[1]) chk("p_data1", pd[1], e.d1);
    endtask

    // Called at posedge+1: drive, queue expectation, check at negedge, let the edge commit.
    task automatic apply(input logic cs, input logic [31:0] cdat, input logic [1:0] dr, input exp_t e);
        c_srdy = cs;
        c_data = cdat;
        p_drdy = dr;
        sb.push_back(e);
        @(negedge clk);
        check_sb();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(bit s6, logic [1:0] srdy, logic [31:0] d0, logic [31:0] d1,
                                logic [1:0] mask, logic cdrdy, logic [3:0] us);
        exp_t e;
        e.sel6 = s6; e.srdy = srdy; e.d0 = d0; e.d1 = d1;
        e.mask = mask; e.cdrdy = cdrdy; e.usage = us;
        return e;
    endfunction

    task automatic add(bit rst, logic cs, logic [31:0] cd, logic [1:0] dr, exp_t e);
        vec_t v;
        v.rst = rst; v.c_srdy = cs; v.c_data = cd; v.p_drdy = dr; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic add_drain_to_one();
        add(1, 0, 0, 2'b11, mk(0, 2'b11, 0, 1, 2'b11, 0, 8));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 2, 3, 2'b11, 1, 6));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 4, 5, 2'b11, 1, 4));
        add(0, 0, 0, 2'b01, mk(0, 2'b11, 6, 7, 2'b11, 1, 2));
    endtask

    logic [31:0] fq[$];
    logic [31:0] outq[$];

    initial begin
        // Dual allocate from reset, full drain
        add(1, 0, 0, 2'b00, mk(0, 2'b11, 0, 0, 2'b11, 0, 8));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 0, 1, 2'b11, 0, 8));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 2, 3, 2'b11, 1, 6));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 4, 5, 2'b11, 1, 4));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 6, 7, 2'b11, 1, 2));
        add(0, 0, 0, 2'b00, mk(0, 2'b00, 0, 0, 2'b00, 1, 0));
        // Lane 1 alone takes the head
        add(1, 0, 0, 2'b10, mk(0, 2'b11, 0, 0, 2'b11, 0, 8));
        add(0, 0, 0, 2'b00, mk(0, 2'b11, 1, 1, 2'b11, 1, 7));
        // Count 1: both lanes ready -> only lane 0
        add_drain_to_one();
        add(0, 0, 0, 2'b11, mk(0, 2'b01, 7, 0, 2'b01, 1, 1));
        add(0, 0, 0, 2'b00, mk(0, 2'b00, 0, 0, 2'b00, 1, 0));
        // Count 1: only lane 1 ready -> lane 1 gets the last ID
        add_drain_to_one();
        add(0, 0, 0, 2'b10, mk(0, 2'b11, 7, 7, 2'b11, 1, 1));
        add(0, 0, 0, 2'b00, mk(0, 2'b00, 0, 0, 2'b00, 1, 0));
        // Full pool refuses a return even while popping; accepted next cycle
        add(1, 1, 32'h55, 2'b01, mk(0, 2'b11, 0, 1, 2'b11, 0, 8));
        add(0, 1, 32'h55, 2'b00, mk(0, 2'b11, 1, 1, 2'b11, 1, 7));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 1, 2, 2'b11, 0, 8));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 3, 4, 2'b11, 1, 6));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 5, 6, 2'b11, 1, 4));
        add(0, 0, 0, 2'b11, mk(0, 2'b11, 7, 32'h55, 2'b11, 1, 2));

        #2;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].c_srdy, vecs[i].c_data, vecs[i].p_drdy, vecs[i].e);
        end

        // depth-6 wrap sequence
        do_reset();
        apply(0, 0,  2'b11, mk(1, 2'b11, 0, 1, 2'b11, 0, 6));
        apply(0, 0,  2'b11, mk(1, 2'b11, 2, 3, 2'b11, 1, 4));
        apply(0, 0,  2'b01, mk(1, 2'b11, 4, 5, 2'b11, 1, 2));
        apply(1, 9,  2'b00, mk(1, 2'b11, 5, 5, 2'b11, 1, 1));
        apply(1, 10, 2'b00, mk(1, 2'b11, 5, 5, 2'b11, 1, 2));
        apply(0, 0,  2'b11, mk(1, 2'b11, 5, 9, 2'b11, 1, 3));
        apply(1, 11, 2'b01, mk(1, 2'b01, 10, 0, 2'b01, 1, 1));
        apply(0, 0,  2'b00, mk(1, 2'b11, 11, 11, 2'b11, 1, 1));

        // Randomized traffic against a free-list model
        do_reset();
        fq.delete();
        outq.delete();
        for (int k = 0; k < 8; k++) fq.push_back(k);
        for (int n = 0; n < 300; n++) begin
            logic [1:0] dr;
            logic cs;
            logic [31:0] cd;
            int idx;
            int np;
            exp_t e;
            dr  = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
            cs  = (outq.size() > 0) && ($urandom_range(0, 3) != 0);
            idx = 0;
            cd  = '0;
            if (cs) begin
                idx = $urandom_range(0, outq.size() - 1);
                cd  = outq[idx];
            end
            e.sel6    = 0;
            e.srdy[0] = fq.size() > 0;
            e.srdy[1] = (fq.size() >= 2) || (fq.size() == 1 && !dr[0]);
            e.mask    = e.srdy;
            e.d0      = (fq.size() > 0) ? fq[0] : '0;
            e.d1      = (dr[0] && fq.size() >= 2) ? fq[1] : e.d0;
            e.cdrdy   = fq.size() < 8;
            e.usage   = 4'(fq.size());
            apply(cs, cd, dr, e);
            np = int'(e.srdy[0] & dr[0]) + int'(e.srdy[1] & dr[1]);
            for (int k = 0; k < np; k++) outq.push_back(fq.pop_front());
            if (cs && e.cdrdy) begin
                fq.push_back(cd);
                outq.delete(idx);
            end
        end

        // Asynchronous reset between clock edges
        do_reset();
        c_srdy = 0;
        p_drdy = 2'b11;
        @(posedge clk);
        #1 p_drdy = 2'b00;
        chk("pre_rst_usage", {28'd0, usage8}, 32'd6);
        chk("pre_rst_head", p_data8[0], 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_usage8", {28'd0, usage8}, 32'd8);
        chk("async_head8", p_data8[0], 32'd0);
        chk("async_cdrdy8", {31'd0, c_drdy8}, 32'd0);
        chk("async_srdy8", {30'd0, p_srdy8}, 32'd3);
        chk("async_usage6", {28'd0, usage6}, 32'd6);
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(0, 0, 2'b11, mk(0, 2'b11, 0, 1, 2'b11, 0, 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
